// File: rtl/uart_rx_buffer.sv
// 16x-oversampled 8N1 UART receiver feeding a show-ahead byte FIFO with sticky error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and the parity_err output.
module uart_rx_buffer #(
  parameter int unsigned BAUD_DIV   = 651,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  UART_RX,
  input  logic                  rd,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  overrun,
  output logic                  frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                  parity_err,
`endif
  input  logic                  clr_err
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned DivW  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [DivW-1:0]       div_q, div_d;
  logic [3:0]            tcnt_q, tcnt_d;
  logic [2:0]            bidx_q, bidx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [7:0]            mem [Depth];
  logic                  tick, push, pop, full, wr_en, ovr_set, fe_set;
`ifdef UART_RX_PARITY_EN
  logic                  par_bad_q, par_bad_d, parity_err_q, parity_err_d, par_set;
`endif

  always_comb begin
    sync1_d  = UART_RX;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    tick     = (div_q == DivW'(BAUD_DIV - 1));
    div_d    = tick ? '0 : div_q + DivW'(1);
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    bidx_d   = bidx_q;
    shift_d  = shift_q;
    push     = 1'b0;
    fe_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    par_set   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        // Edge-triggered so a line stuck low cannot start back-to-back frames
        if (prev_q && !sync2_q) begin
          state_d = StStart;
          tcnt_d  = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      StStart: begin
        if (tick) begin
          if (tcnt_q == 4'd7) begin
            if (sync2_q) begin
              state_d = StIdle;
            end else begin
              state_d = StData;
              tcnt_d  = '0;
              bidx_d  = '0;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            shift_d = {sync2_q, shift_q[7:1]};
            bidx_d  = bidx_q + 3'd1;
            if (bidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            par_bad_d = ^{shift_q, sync2_q};
            par_set   = par_bad_d;
            state_d   = StStop;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            state_d = StIdle;
            if (!sync2_q) begin
              fe_set = 1'b1;
            end else begin
`ifdef UART_RX_PARITY_EN
              push = !par_bad_q;
`else
              push = 1'b1;
`endif
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    pop       = rd && (count_q != '0);
    full      = (count_q == CntW'(Depth));
    // A pop in the same cycle frees the slot the push lands in
    wr_en     = push && (!full || pop);
    ovr_set   = push && full && !pop;
    count_d   = count_q + CntW'(wr_en) - CntW'(pop);
    wr_ptr_d  = wr_en ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    overrun_d   = (overrun_q && !clr_err) || ovr_set;
    frame_err_d = (frame_err_q && !clr_err) || fe_set;
`ifdef UART_RX_PARITY_EN
    parity_err_d = (parity_err_q && !clr_err) || par_set;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      div_q       <= '0;
      tcnt_q      <= '0;
      bidx_q      <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      div_q       <= div_d;
      tcnt_q      <= tcnt_d;
      bidx_q      <= bidx_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= shift_q;
    end
  end

  assign rx_valid  = (count_q != '0);
  assign rx_data   = rx_valid ? mem[rd_ptr_q] : 8'h00;
  assign rx_count  = count_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer with BAUD_DIV=4 (one bit = 64 clk).
// Honours UART_RX_PARITY_EN when defined for the DUT build.
module tb_uart_rx_buffer;

  logic       clk, reset, UART_RX, rd, clr_err;
  logic [7:0] rx_data;
  logic       rx_valid, overrun, frame_err;
  logic [2:0] rx_count;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif

  uart_rx_buffer #(
    .BAUD_DIV   (4),
    .DEPTH_LOG2 (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .UART_RX   (UART_RX),
    .rd        (rd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_count  (rx_count),
    .overrun   (overrun),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .clr_err   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; the baud tick fires when cyc % 4 == 3.
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_err    = 0;
  int rise_cyc;
  int stop_cyc;

  typedef struct {
    logic       snd;
    logic [7:0] data;
    logic       stp;
    int         pops;
    logic       clr;
    logic       e_valid;
    logic [7:0] e_data;
    int         e_count;
    logic       e_ovr;
    logic       e_fe;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic snd, input logic [7:0] data, input logic stp,
                              input int pops, input logic clr, input logic e_valid,
                              input logic [7:0] e_data, input int e_count, input logic e_ovr,
                              input logic e_fe);
    vec_t v;
    v.snd = snd; v.data = data; v.stp = stp; v.pops = pops; v.clr = clr;
    v.e_valid = e_valid; v.e_data = e_data; v.e_count = e_count;
    v.e_ovr = e_ovr; v.e_fe = e_fe;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_one();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // Drives one frame from a negedge; predicts the stop-sample cycle from the tick phase.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                            input logic rd_at_push);
    logic [10:0] frm;
    logic        pv;
    int          t1;
`ifdef UART_RX_PARITY_EN
    frm = {stop_bit, par_bit, b, 1'b0};
`else
    frm = {1'b0, stop_bit, b, 1'b0};
    pv  = par_bit;
`endif
    t1 = cyc + 3;
    while (t1 % 4 != 3) t1++;
    stop_cyc = t1 + 604 + (NBits - 10) * 64;
    rise_cyc = -1;
    pv = rx_valid;
    for (int i = 0; i < NBits * 64; i++) begin
      UART_RX = frm[i / 64];
      if (rd_at_push) rd = (cyc == stop_cyc);
      if (rx_valid && !pv && rise_cyc < 0) rise_cyc = cyc;
      pv = rx_valid;
      @(negedge clk);
    end
    rd = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic e_valid, input logic [7:0] e_data,
                               input int e_count, input logic e_ovr, input logic e_fe);
    check({tag, " valid"}, rx_valid, e_valid);
    if (e_valid) check({tag, " data"}, rx_data, e_data);
    check({tag, " count"}, rx_count, e_count);
    check({tag, " overrun"}, overrun, e_ovr);
    check({tag, " frame_err"}, frame_err, e_fe);
  endtask

  initial begin
    logic [7:0] exp_q [4];
    UART_RX = 1'b1; rd = 1'b0; clr_err = 1'b0; reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(10);
    check_outputs("reset", 1'b0, 8'h00, 0, 1'b0, 1'b0);
    check("reset data", rx_data, 8'h00);

    tbl[0]  = mk(1, 8'hA5, 1, 0, 0, 1, 8'hA5, 1, 0, 0);
    tbl[1]  = mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    tbl[2]  = mk(1, 8'h01, 1, 0, 0, 1, 8'h01, 1, 0, 0);
    tbl[3]  = mk(1, 8'h02, 1, 0, 0, 1, 8'h01, 2, 0, 0);
    tbl[4]  = mk(1, 8'h03, 1, 0, 0, 1, 8'h01, 3, 0, 0);
    tbl[5]  = mk(1, 8'h04, 1, 0, 0, 1, 8'h01, 4, 0, 0);
    tbl[6]  = mk(1, 8'h05, 1, 0, 0, 1, 8'h01, 4, 1, 0);
    tbl[7]  = mk(0, 8'h00, 1, 1, 0, 1, 8'h02, 3, 1, 0);
    tbl[8]  = mk(0, 8'h00, 1, 1, 0, 1, 8'h03, 2, 1, 0);
    tbl[9]  = mk(0, 8'h00, 1, 1, 0, 1, 8'h04, 1, 1, 0);
    tbl[10] = mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 1, 0);
    tbl[11] = mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 1, 0);
    tbl[12] = mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 0);
    tbl[13] = mk(1, 8'h3C, 0, 0, 0, 0, 8'h00, 0, 0, 1);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].snd) send_frame(tbl[i].data, tbl[i].stp, ^tbl[i].data, 1'b0);
      if (i == 0) check("v0 rise cycle", rise_cyc, stop_cyc + 1);
      for (int p = 0; p < tbl[i].pops; p++) pop_one();
      if (tbl[i].clr) clr_pulse();
      check_outputs($sformatf("v%0d", i), tbl[i].e_valid, tbl[i].e_data, tbl[i].e_count,
                    tbl[i].e_ovr, tbl[i].e_fe);
    end

    // Line left low after the bad stop bit must not start a frame
    idle(700);
    check_outputs("held low", 1'b0, 8'h00, 0, 1'b0, 1'b1);
    UART_RX = 1'b1;
    idle(100);
    check("after low count", rx_count, 0);
    clr_pulse();
    check("clr frame_err", frame_err, 1'b0);

    // Short glitch on an idle line
    UART_RX = 1'b0;
    idle(20);
    UART_RX = 1'b1;
    idle(200);
    check_outputs("glitch", 1'b0, 8'h00, 0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, ^8'h11, 1'b0);
    check_outputs("post glitch", 1'b1, 8'h11, 1, 1'b0, 1'b0);
    pop_one();

    // Full FIFO with a pop on the same edge as the push
    send_frame(8'h10, 1'b1, ^8'h10, 1'b0);
    send_frame(8'h20, 1'b1, ^8'h20, 1'b0);
    send_frame(8'h30, 1'b1, ^8'h30, 1'b0);
    send_frame(8'h40, 1'b1, ^8'h40, 1'b0);
    check("fill count", rx_count, 4);
    send_frame(8'h77, 1'b1, ^8'h77, 1'b1);
    check_outputs("push+pop full", 1'b1, 8'h20, 4, 1'b0, 1'b0);
    exp_q[0] = 8'h20; exp_q[1] = 8'h30; exp_q[2] = 8'h40; exp_q[3] = 8'h77;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain head %0d", k), rx_data, exp_q[k]);
      pop_one();
    end
    check("drain count", rx_count, 0);

    // Mid-frame reset with state to clear
    send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0);
    UART_RX = 1'b1;
    idle(20);
    send_frame(8'h66, 1'b1, ^8'h66, 1'b0);
    check_outputs("pre reset", 1'b1, 8'h66, 1, 1'b0, 1'b1);
    UART_RX = 1'b0; idle(64);
    UART_RX = 1'b1; idle(64);
    UART_RX = 1'b0; idle(50);
    #1 reset = 1'b1;
    #2 check_outputs("in reset", 1'b0, 8'h00, 0, 1'b0, 1'b0);
    check("in reset data", rx_data, 8'h00);
    idle(3);
    reset = 1'b0;
    UART_RX = 1'b1;
    idle(100);
    check_outputs("after reset", 1'b0, 8'h00, 0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0);
    check_outputs("after reset rx", 1'b1, 8'h5A, 1, 1'b0, 1'b0);
    pop_one();

`ifdef UART_RX_PARITY_EN
    check("parity_err init", parity_err, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    check("bad parity flag", parity_err, 1'b1);
    check("bad parity count", rx_count, 0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check("good parity count", rx_count, 1);
    check("good parity data", rx_data, 8'h07);
    clr_pulse();
    check("clr parity_err", parity_err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
